// File: rtl/entropy_pkg.sv
// Shared constants and types for the AC entropy scan path.
package entropy_pkg;

    localparam int COEFF_W = 20;

    // Progressive scan: maps scan position to raster index within an 8x8 block
    localparam logic [5:0] SCAN_PROG [64] = '{
        6'd0,  6'd1,  6'd8,  6'd9,  6'd2,  6'd3,  6'd10, 6'd11,
        6'd16, 6'd17, 6'd24, 6'd25, 6'd18, 6'd19, 6'd26, 6'd27,
        6'd4,  6'd5,  6'd12, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14,
        6'd21, 6'd28, 6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd31,
        6'd32, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34, 6'd35, 6'd42,
        6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36, 6'd37, 6'd44,
        6'd51, 6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/entropy_skid_fifo2.sv
// Two-entry FIFO that soaks up read data returning after the consumer stalls.
module entropy_skid_fifo2 #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // Storage carries no reset; count qualifies its contents
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wdata;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/entropy_ac_scan_sequencer.sv
// Streams a slice's AC coefficients (scan pos 1..63, block-interleaved) from the
// coefficient buffer to the run/level encoder with ready/valid flow control.
module entropy_ac_scan_sequencer #(
    parameter int COEFF_W      = entropy_pkg::COEFF_W,
    parameter int MAX_BLK_LOG2 = 3,
    parameter int ADDR_W       = MAX_BLK_LOG2 + 6
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         blk_log2,
    output logic               busy,
    output logic               done,
    output logic               enc_clear,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [COEFF_W-1:0] rd_data,
    output logic               coeff_valid,
    output logic [COEFF_W-1:0] coeff_data,
    output logic               coeff_last,
    input  logic               coeff_ready
);

    import entropy_pkg::*;

    state_e                  state_q;
    state_e                  state_d;
    logic [1:0]              lg_q;
    logic [1:0]              lg_start;
    logic [5:0]              pos_q;
    logic [MAX_BLK_LOG2-1:0] blk_q;
    logic [MAX_BLK_LOG2-1:0] blk_mask;
    logic                    last_rd;
    logic                    credit_ok;
    logic                    hs;
    logic [1:0]              occ;
    logic                    vld_p1;
    logic                    last_p1;
    logic [1:0]              fifo_count;
    logic [COEFF_W:0]        fifo_head;
    logic                    fifo_push;
    logic                    fifo_pop;

    always_comb begin
        lg_start = blk_log2;
        if ({30'd0, blk_log2} > 32'(MAX_BLK_LOG2)) lg_start = 2'(MAX_BLK_LOG2);
    end

    always_comb begin
        blk_mask = '0;
        for (int i = 0; i < MAX_BLK_LOG2; i++) begin
            blk_mask[i] = (i < int'(lg_q));
        end
    end

    assign last_rd = (pos_q == 6'd63) && (blk_q == blk_mask);

    // Credit counts FIFO entries plus the read in flight; a same-cycle pop frees one slot
    assign occ       = fifo_count + {1'b0, vld_p1};
    assign hs        = coeff_valid & coeff_ready;
    assign credit_ok = ({1'b0, occ} < (3'd2 + {2'b0, hs}));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        busy      = 1'b0;
        done      = 1'b0;
        enc_clear = 1'b0;
        rd_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = CLEAR;
            end
            CLEAR: begin
                busy      = 1'b1;
                enc_clear = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                busy  = 1'b1;
                rd_en = credit_ok;
                if (credit_ok && last_rd) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Leave when this cycle's handshake empties everything
                if (occ == {1'b0, hs}) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Stage p0: scan counters and address generation
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lg_q  <= 2'd0;
            pos_q <= 6'd0;
            blk_q <= '0;
        end else if (state_q == IDLE && start) begin
            lg_q  <= lg_start;
            pos_q <= 6'd1;
            blk_q <= '0;
        end else if (rd_en) begin
            if (blk_q == blk_mask) begin
                blk_q <= '0;
                pos_q <= pos_q + 6'd1;
            end else begin
                blk_q <= blk_q + 1'b1;
            end
        end
    end

    assign rd_addr = rd_en ? {blk_q, SCAN_PROG[pos_q]} : '0;

    // Stage p1: buffer read returning, tagged with the slice-last flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= rd_en;
            last_p1 <= rd_en & last_rd;
        end
    end

    // Returning data bypasses straight to the output when the FIFO is empty and ready is high
    assign fifo_pop  = (fifo_count != 2'd0) & coeff_ready;
    assign fifo_push = vld_p1 & ~((fifo_count == 2'd0) & coeff_ready);

    entropy_skid_fifo2 #(
        .W (COEFF_W + 1)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   ({last_p1, rd_data}),
        .head    (fifo_head),
        .count   (fifo_count)
    );

    assign coeff_valid = (fifo_count != 2'd0) | vld_p1;

    always_comb begin
        coeff_data = '0;
        coeff_last = 1'b0;
        if (fifo_count != 2'd0) begin
            coeff_data = fifo_head[COEFF_W-1:0];
            coeff_last = fifo_head[COEFF_W];
        end else if (vld_p1) begin
            coeff_data = rd_data;
            coeff_last = last_p1;
        end
    end

endmodule

// File: doc/entropy_ac_scan_sequencer.md
Name: entropy_ac_scan_sequencer

Overview:
Sequences one slice's quantized AC coefficients from the slice coefficient buffer into the AC run/level entropy encoder. It walks scan positions 1..63 in progressive scan order, interleaved across all blocks of the slice. It generates buffer read addresses and absorbs the buffer's 1-cycle read latency with a 2-entry skid FIFO. It emits a ready/valid coefficient stream, and pulses a clear to the encoder so run state restarts at each slice.

Parameters:
COEFF_W, 20, coefficient width (sign bit + 1 guard bit, matches encoder Coeff input)
MAX_BLK_LOG2, 3, log2 of maximum blocks per slice (8)
ADDR_W, 9, buffer address width = MAX_BLK_LOG2 + 6

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
start  in  1  begin slice; sampled only in IDLE
blk_log2  in  2  log2 blocks in slice; latched at start; values > MAX_BLK_LOG2 clamp to MAX_BLK_LOG2
busy  out  1  high from the cycle after start until done
done  out  1  one-cycle pulse when the slice is fully handed off
enc_clear  out  1  one-cycle pulse; encoder reloads previousRun=4, run=0
rd_en  out  1  coefficient buffer read strobe
rd_addr  out  ADDR_W  {blk, scan[pos]}
rd_data  in  COEFF_W  buffer data, valid the cycle after rd_en
coeff_valid  out  1  stream valid
coeff_data  out  COEFF_W  coefficient to encoder
coeff_last  out  1  marks final coefficient of slice
coeff_ready  in  1  encoder accepts when valid & ready

Behaviour:
- Reset values: busy=0, done=0, enc_clear=0, rd_en=0, rd_addr=0, coeff_valid=0, coeff_data=0, coeff_last=0. State is IDLE, FIFO is empty, counters are 0.
- Reset mid-slice: immediate return to IDLE; the FIFO and in-flight read are discarded; no done pulse.
- States:
  - IDLE: start=1 -> CLEAR.
  - CLEAR: enc_clear=1 for one cycle -> RUN.
  - RUN: issue reads -> DRAIN after the last read is issued.
  - DRAIN: wait until the FIFO is empty and no read is in flight -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- busy=1 in CLEAR, RUN and DRAIN; busy=0 in DONE.
- start outside IDLE is ignored.
- Order: N = 1<<blk_log2. Read index k runs 0..63N-1. pos = 1 + (k >> blk_log2), blk = k & (N-1). rd_addr = blk*64 + SCAN[pos]. DC (pos 0) is never read.
- Counters: pos is 6 bits and blk is MAX_BLK_LOG2 bits. blk wraps N-1 -> 0 and increments pos. The last read is pos=63, blk=N-1.
- Read credit: a read is issued in a RUN cycle iff fifo_count + inflight - pop < 2, where pop = coeff_valid & coeff_ready. This sustains 1 coefficient/cycle with ready held high.
- FIFO: 2 entries. The rd_data push occurs the cycle after rd_en. The FIFO head drives coeff_data. coeff_last is carried as a tag bit, set on k = 63N-1.
- Simultaneous push and pop with count=2 cannot occur, because the credit rule prevents it.
- coeff_data and coeff_last are held stable while valid & !ready.
- Timing with start at cycle T and ready high:
  - CLEAR/enc_clear and busy at T+1.
  - First rd_en at T+2.
  - First coeff_valid at T+3.
  - Last handshake at T+63N+2.
  - done at T+63N+3.
- Generally, done is asserted the cycle after the handshake carrying coeff_last.
- Coefficients pass through unmodified; no width change.

Decomposition:
- Package entropy_pkg:
  - SCAN_PROG: 64 x 6-bit progressive scan constant; entries 0..7 = 0,1,8,9,2,3,10,11.
  - State enum {IDLE, CLEAR, RUN, DRAIN, DONE}.
  - COEFF_W.
- Sub-module: entropy_skid_fifo2. 2-entry, COEFF_W+1 bits wide, with push/pop/count/head ports.

Test Plan:
- blk_log2=0, buffer[a]=a, ready=1 -> 63 coefficients; the first three coeff_data are 1, 8, 9. coeff_last only on the 63rd. done at T+66. enc_clear pulses once at T+1.
- blk_log2=2, buffer[a]=a -> 252 coefficients; the first eight are 1, 65, 129, 193, 8, 72, 136, 200. The last is 192+SCAN[63].
- blk_log2=1 with ready toggling 1/0 and 5-cycle stalls -> no drops or duplicates, data stable during stalls. Output sequence matches the ready=1 run; rd_en never issued when fifo_count+inflight=2.
- start pulsed again during RUN -> ignored: one enc_clear, one done. blk_log2 changed mid-slice -> no effect.
- reset_n asserted after 10 handshakes -> all outputs 0 immediately. A fresh start then restarts at pos=1, blk=0 with a new enc_clear.
- blk_log2=3 -> 504 coefficients with the last address 448+SCAN[63]. With MAX_BLK_LOG2=2 instantiated, blk_log2=3 clamps to 252 coefficients.
